// File: rtl/radix4_divider_seq.sv
// ============================================================================
// radix4_divider_seq
//
// Sequential radix-4 restoring divider. One quotient digit (2 bits) is
// produced per clock, so a NUM_BITS divide takes NUM_BITS/2 iteration
// cycles plus one cycle for sign fixup. Signed operation works on absolute
// values and restores signs at the end: the quotient truncates toward zero
// and the remainder takes the sign of the dividend.
//
// Two operand patterns bypass the iteration entirely and go straight to
// fixup:
//   divisor == 0                 -> quotient all ones, remainder = dividend,
//                                   div_by_zero set
//   signed most-negative / -1    -> quotient = dividend, remainder = 0,
//                                   overflow set
//
// Ports
//   CLK          rising-edge clock
//   RST          asynchronous active-high reset
//   start        begin a new divide; accepted in any state, so it also
//                aborts and restarts a divide that is in flight
//   is_signed    two's-complement operands when 1 (sampled with start)
//   dividend     numerator (sampled with start)
//   divisor      denominator (sampled with start)
//   quotient     registered result, valid while finished = 1
//   remainder    registered result, valid while finished = 1
//   busy         high while iterating or fixing up signs
//   finished     high from completion until the next start or reset
//   div_by_zero  current result came from a zero divisor
//   overflow     current result came from signed most-negative / -1
// ============================================================================
module radix4_divider_seq #(
    parameter int NUM_BITS = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                is_signed,
    input  logic [NUM_BITS-1:0] dividend,
    input  logic [NUM_BITS-1:0] divisor,
    output logic [NUM_BITS-1:0] quotient,
    output logic [NUM_BITS-1:0] remainder,
    output logic                busy,
    output logic                finished,
    output logic                div_by_zero,
    output logic                overflow
);

    localparam int STEPS = NUM_BITS / 2;
    localparam int CNT_W = $clog2(STEPS + 1);

    localparam logic [NUM_BITS-1:0] ZERO_C     = {NUM_BITS{1'b0}};
    localparam logic [NUM_BITS-1:0] ONES_C     = {NUM_BITS{1'b1}};
    localparam logic [NUM_BITS-1:0] MOST_NEG_C = {1'b1, {(NUM_BITS-1){1'b0}}};
    localparam logic [CNT_W-1:0]    CNT_ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_LAST_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_STEPS_C = CNT_W'(STEPS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Two's-complement negation at operand width.
    function automatic logic [NUM_BITS-1:0] negate(input logic [NUM_BITS-1:0] x);
        return ~x + {{(NUM_BITS-1){1'b0}}, 1'b1};
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [NUM_BITS-1:0] prem_r;      // partial remainder (always < |divisor|)
    logic [NUM_BITS-1:0] quo_r;       // dividend bits shift out the top, digits in the bottom
    logic [NUM_BITS-1:0] dabs_r;      // |divisor|
    logic                q_neg_r;     // quotient must be negated in fixup
    logic                r_neg_r;     // remainder must be negated in fixup
    logic                special_r;   // result was preloaded, skip sign fixup

    logic                div0_s;
    logic                ovf_s;
    logic [NUM_BITS-1:0] dividend_abs_s;
    logic [NUM_BITS-1:0] divisor_abs_s;

    logic [NUM_BITS+1:0] shifted_s;
    logic [NUM_BITS+1:0] d1_s;
    logic [NUM_BITS+1:0] d2_s;
    logic [NUM_BITS+1:0] d3_s;
    logic [1:0]          digit_s;
    logic [NUM_BITS-1:0] prem_nxt_s;
    logic [NUM_BITS-1:0] quo_nxt_s;

    logic [NUM_BITS-1:0] q_fix_s;
    logic [NUM_BITS-1:0] r_fix_s;

    // Special-case detection and absolute values of the incoming operands.
    always_comb begin
        div0_s = (divisor == ZERO_C);
        ovf_s  = is_signed && (dividend == MOST_NEG_C) && (divisor == ONES_C);
        if (is_signed && dividend[NUM_BITS-1]) begin
            dividend_abs_s = negate(dividend);
        end else begin
            dividend_abs_s = dividend;
        end
        if (is_signed && divisor[NUM_BITS-1]) begin
            divisor_abs_s = negate(divisor);
        end else begin
            divisor_abs_s = divisor;
        end
    end

    // One radix-4 step: bring in two dividend bits, pick the largest digit
    // whose multiple of D fits. 3D is formed at NUM_BITS+2 bits so it never
    // wraps.
    always_comb begin
        shifted_s  = {prem_r, quo_r[NUM_BITS-1 -: 2]};
        d1_s       = {2'b00, dabs_r};
        d2_s       = {1'b0, dabs_r, 1'b0};
        d3_s       = d1_s + d2_s;
        digit_s    = 2'd0;
        prem_nxt_s = shifted_s[NUM_BITS-1:0];
        if (shifted_s >= d3_s) begin
            digit_s    = 2'd3;
            prem_nxt_s = NUM_BITS'(shifted_s - d3_s);
        end else if (shifted_s >= d2_s) begin
            digit_s    = 2'd2;
            prem_nxt_s = NUM_BITS'(shifted_s - d2_s);
        end else if (shifted_s >= d1_s) begin
            digit_s    = 2'd1;
            prem_nxt_s = NUM_BITS'(shifted_s - d1_s);
        end else begin
            digit_s    = 2'd0;
            prem_nxt_s = shifted_s[NUM_BITS-1:0];
        end
        quo_nxt_s = {quo_r[NUM_BITS-3:0], digit_s};
    end

    // Sign restoration applied when leaving FIXUP.
    always_comb begin
        if (q_neg_r && !special_r) begin
            q_fix_s = negate(quo_r);
        end else begin
            q_fix_s = quo_r;
        end
        if (r_neg_r && !special_r) begin
            r_fix_s = negate(prem_r);
        end else begin
            r_fix_s = prem_r;
        end
    end

    // Next-state logic; start wins over every state so it can abort a divide.
    always_comb begin
        state_nxt_s = state_r;
        if (start) begin
            if (div0_s || ovf_s) begin
                state_nxt_s = FIXUP;
            end else begin
                state_nxt_s = DIVIDE;
            end
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = IDLE;
                DIVIDE: begin
                    if (cnt_r == CNT_LAST_C) begin
                        state_nxt_s = FIXUP;
                    end else begin
                        state_nxt_s = DIVIDE;
                    end
                end
                FIXUP:   state_nxt_s = DONE;
                DONE:    state_nxt_s = DONE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register with registered busy/finished decoded from the next state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            finished <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            busy     <= (state_nxt_s == DIVIDE) || (state_nxt_s == FIXUP);
            finished <= (state_nxt_s == DONE);
        end
    end

    // Datapath: operand capture, iteration, and result/flag registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r       <= CNT_ZERO_C;
            prem_r      <= ZERO_C;
            quo_r       <= ZERO_C;
            dabs_r      <= ZERO_C;
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            special_r   <= 1'b0;
            quotient    <= ZERO_C;
            remainder   <= ZERO_C;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (start) begin
            dabs_r      <= divisor_abs_s;
            q_neg_r     <= is_signed && (dividend[NUM_BITS-1] ^ divisor[NUM_BITS-1]);
            r_neg_r     <= is_signed && dividend[NUM_BITS-1];
            special_r   <= div0_s || ovf_s;
            div_by_zero <= div0_s;
            overflow    <= ovf_s;
            if (div0_s) begin
                cnt_r  <= CNT_ZERO_C;
                quo_r  <= ONES_C;
                prem_r <= dividend;
            end else if (ovf_s) begin
                cnt_r  <= CNT_ZERO_C;
                quo_r  <= dividend;
                prem_r <= ZERO_C;
            end else begin
                cnt_r  <= CNT_STEPS_C;
                quo_r  <= dividend_abs_s;
                prem_r <= ZERO_C;
            end
        end else begin
            case (state_r)
                DIVIDE: begin
                    prem_r <= prem_nxt_s;
                    quo_r  <= quo_nxt_s;
                    cnt_r  <= cnt_r - CNT_LAST_C;
                end
                FIXUP: begin
                    quotient  <= q_fix_s;
                    remainder <= r_fix_s;
                end
                default: begin
                    // IDLE and DONE hold everything.
                end
            endcase
        end
    end

endmodule
